// File: rtl/spi_master_multi.sv
// Parametrised SPI master with runtime CPOL/CPHA/bit order and CS_NUM active-low chip selects.
// The SCLK half-period is CLK_DIV clocks. CS setup and CS hold each last one half-period.
module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int CS_NUM  = 4,
  parameter int CLK_DIV = 4,
  parameter int CS_W    = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic [CS_W-1:0]   i_cs_sel,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_miso,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic [CS_NUM-1:0] o_cs_n,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_err
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TOG_W = $clog2(2 * DATA_W + 1);
  localparam int BI_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_W - 1);
  localparam logic [BI_W-1:0]  BIT_LAST = BI_W'(DATA_W - 1);
  localparam logic [CS_W:0]    CS_LIM   = (CS_W + 1)'(CS_NUM);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TOG_W-1:0]    tog_q, tog_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DATA_W-1:0]   tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d;
  logic [CS_NUM-1:0]   cs_n_q, cs_n_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [CS_NUM-1:0]   cs_dec;
  logic                sel_ok, tick;
  logic [BI_W-1:0]     bit_n, nxt_n, bit_pos, nxt_pos;

  for (genvar gi = 0; gi < CS_NUM; gi++) begin : g_cs_dec
    assign cs_dec[gi] = (i_cs_sel == CS_W'(gi));
  end

  assign sel_ok  = ({1'b0, i_cs_sel} < CS_LIM);
  assign tick    = (cnt_q == CNT_LAST);
  // Toggles 2k-1 and 2k both belong to bit k-1, so the bit number is tog_q/2.
  assign bit_n   = BI_W'(tog_q >> 1);
  assign nxt_n   = bit_n + 1'b1;
  assign bit_pos = lsb_q ? bit_n : BIT_LAST - bit_n;
  assign nxt_pos = lsb_q ? nxt_n : BIT_LAST - nxt_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (sel_ok) begin
            cpol_d  = i_cpol;
            cpha_d  = i_cpha;
            lsb_d   = i_lsb_first;
            tx_d    = i_tx_data;
            rx_sh_d = '0;
            cnt_d   = '0;
            tog_d   = '0;
            sclk_d  = i_cpol;
            cs_n_d  = ~cs_dec;
            busy_d  = 1'b1;
            if (!i_cpha) mosi_d = i_lsb_first ? i_tx_data[0] : i_tx_data[DATA_W-1];
            state_d = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP, XFER: begin
        if (tick) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          tog_d  = tog_q + 1'b1;
          if (!tog_q[0]) begin
            if (cpha_q) mosi_d = tx_q[bit_pos];
            else        rx_sh_d[bit_pos] = i_miso;
          end else begin
            if (cpha_q)                  rx_sh_d[bit_pos] = i_miso;
            else if (tog_q != TOG_LAST)  mosi_d = tx_q[nxt_pos];
          end
          state_d = (tog_q == TOG_LAST) ? HOLD : XFER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          cnt_d   = '0;
          sclk_d  = cpol_q;
          cs_n_d  = '1;
          rx_d    = rx_sh_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_sclk    = sclk_q;
  assign o_mosi    = mosi_q;
  assign o_cs_n    = cs_n_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_rx_data = rx_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: a behavioural SPI slave acts as the reference for every mode.
// A second instance covers DATA_W=16 with CLK_DIV=1.
module tb_spi_master_multi;
  localparam int DW = 8, CSN = 4, CD = 4, CSW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: CS_W widened so an out-of-range index can be presented.
  logic             start, cpol, cpha, lsb;
  logic [CSW-1:0]   cs_sel;
  logic [DW-1:0]    tx;
  logic             miso, sclk, mosi, busy, done, err;
  logic [CSN-1:0]   cs_n;
  logic [DW-1:0]    rx;
  bit               lpbk;

  spi_master_multi #(.DATA_W(DW), .CS_NUM(CSN), .CLK_DIV(CD), .CS_W(CSW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cpol(cpol), .i_cpha(cpha),
    .i_lsb_first(lsb), .i_cs_sel(cs_sel), .i_tx_data(tx), .i_miso(miso),
    .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n), .o_busy(busy), .o_done(done),
    .o_rx_data(rx), .o_err(err));

  // Wide/fast instance, MISO looped back to MOSI.
  logic         start16, cpol16, cpha16, lsb16;
  logic [0:0]   sel16;
  logic [15:0]  tx16, rx16;
  logic         sclk16, mosi16, busy16, done16, err16;
  logic [1:0]   cs16;
  wire          miso16 = mosi16;

  spi_master_multi #(.DATA_W(16), .CS_NUM(2), .CLK_DIV(1)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start16), .i_cpol(cpol16), .i_cpha(cpha16),
    .i_lsb_first(lsb16), .i_cs_sel(sel16), .i_tx_data(tx16), .i_miso(miso16),
    .o_sclk(sclk16), .o_mosi(mosi16), .o_cs_n(cs16), .o_busy(busy16), .o_done(done16),
    .o_rx_data(rx16), .o_err(err16));

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural slave: textbook SPI mode rules applied to the observed pins.
  logic          slv_cpol, slv_cpha, slv_lsb;
  logic [DW-1:0] slv_word, slv_rx, slv_seq;
  logic          slv_miso = 1'b0;
  int            slv_tx_n = 0, slv_rx_n = 0, slv_rises = 0;
  logic          cs_prev = 1'b0, sclk_prev = 1'b0;

  assign miso = lpbk ? mosi : slv_miso;

  function automatic int pos(int n, logic l);
    return l ? n : DW - 1 - n;
  endfunction

  always @(negedge clk) begin
    if (cs_n != '1 && !cs_prev) begin
      slv_rx    <= '0;
      slv_seq   <= '0;
      slv_rx_n  <= 0;
      slv_rises <= 0;
      if (!slv_cpha) begin
        slv_miso <= slv_word[pos(0, slv_lsb)];
        slv_tx_n <= 1;
      end else begin
        slv_tx_n <= 0;
      end
    end else if (cs_n != '1 && sclk != sclk_prev) begin
      if (sclk) slv_rises <= slv_rises + 1;
      if ((sclk != slv_cpol) ^ slv_cpha) begin
        slv_rx[pos(slv_rx_n, slv_lsb)] <= mosi;
        slv_seq  <= {slv_seq[DW-2:0], mosi};
        slv_rx_n <= slv_rx_n + 1;
      end else if (slv_tx_n < DW) begin
        slv_miso <= slv_word[pos(slv_tx_n, slv_lsb)];
        slv_tx_n <= slv_tx_n + 1;
      end
    end
    cs_prev   <= (cs_n != '1);
    sclk_prev <= sclk;
  end

  task automatic run_xfer(input string tag, input logic p, input logic h, input logic l,
                          input logic [CSW-1:0] sel, input logic [DW-1:0] t,
                          input logic [DW-1:0] sw, input bit lb,
                          input logic [DW-1:0] exp_rx, input logic [CSN-1:0] exp_cs);
    int lat;
    slv_cpol = p; slv_cpha = h; slv_lsb = l; slv_word = sw; lpbk = lb;
    cpol = p; cpha = h; lsb = l; cs_sel = sel; tx = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " cs"}, 64'(cs_n), 64'(exp_cs));
    chk({tag, " busy"}, 64'(busy), 64'(1'b1));
    chk({tag, " sclk idle"}, 64'(sclk), 64'(p));
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(68));
    chk({tag, " rx"}, 64'(rx), 64'(exp_rx));
    chk({tag, " slave rx"}, 64'(slv_rx), 64'(t));
    chk({tag, " rises"}, 64'(slv_rises), 64'(DW));
    chk({tag, " cs end"}, 64'(cs_n), 64'(4'hF));
    chk({tag, " busy end"}, 64'(busy), 64'(1'b0));
    chk({tag, " sclk end"}, 64'(sclk), 64'(p));
    $display("[TB] %s cpol=%0d cpha=%0d lsb=%0d sel=%0d tx=%h rx=%h lat=%0d",
             tag, p, h, l, sel, t, rx, lat);
  endtask

  typedef struct {
    logic           cpol, cpha, lsb;
    logic [CSW-1:0] sel;
    logic [DW-1:0]  tx, sw;
    bit             lb;
    logic [DW-1:0]  exp_rx, exp_seq;
    logic [CSN-1:0] exp_cs;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, seen;
    logic [CSW-1:0] r_sel;
    logic [DW-1:0]  r_tx, r_sw;
    logic           r_p, r_h, r_l;
    logic [15:0]    exp16[2];

    // cpol cpha lsb sel tx sw loopback exp_rx exp_seq(MOSI in wire order) exp_cs
    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd2, 8'hA5, 8'h00, 1'b1, 8'hA5, 8'hA5, 4'b1011};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h81, 8'h3C, 1'b0, 8'h3C, 8'h81, 4'b1110};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd1, 8'hC3, 8'h5A, 1'b0, 8'h5A, 8'hC3, 4'b1101};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 3'd3, 8'h96, 8'h5A, 1'b0, 8'h5A, 8'h96, 4'b0111};
    exp16[0] = 16'hBEEF;
    exp16[1] = 16'h1234;

    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; cs_sel = '0; tx = '0;
    lpbk = 1'b0; slv_cpol = 1'b0; slv_cpha = 1'b0; slv_lsb = 1'b0; slv_word = '0;
    start16 = 1'b0; cpol16 = 1'b0; cpha16 = 1'b0; lsb16 = 1'b0; sel16 = '0; tx16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset sclk", 64'(sclk), 64'(1'b0));
    chk("reset mosi", 64'(mosi), 64'(1'b0));
    chk("reset cs_n", 64'(cs_n), 64'(4'hF));
    chk("reset busy", 64'(busy), 64'(1'b0));
    chk("reset done", 64'(done), 64'(1'b0));
    chk("reset err", 64'(err), 64'(1'b0));
    chk("reset rx", 64'(rx), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i].cpol, vecs[i].cpha, vecs[i].lsb, vecs[i].sel,
               vecs[i].tx, vecs[i].sw, vecs[i].lb, vecs[i].exp_rx, vecs[i].exp_cs);
      chk($sformatf("vec%0d mosi order", i), 64'(slv_seq), 64'(vecs[i].exp_seq));
      @(posedge clk); #1;
    end

    for (int i = 0; i < 20; i++) begin
      r_p = 1'($urandom_range(0, 1));
      r_h = 1'($urandom_range(0, 1));
      r_l = 1'($urandom_range(0, 1));
      r_sel = 3'($urandom_range(0, 3));
      r_tx = 8'($urandom);
      r_sw = 8'($urandom);
      run_xfer($sformatf("rand%0d", i), r_p, r_h, r_l, r_sel, r_tx, r_sw, 1'b0, r_sw,
               ~(4'b0001 << r_sel));
      repeat (1 + $urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Start while busy is ignored, then a start coincident with o_done.
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; cs_sel = 3'd1; tx = 8'h12; lpbk = 1'b0;
    slv_cpol = 1'b0; slv_cpha = 1'b0; slv_lsb = 1'b0; slv_word = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 9) begin
        start = 1'b1; cs_sel = 3'd0; tx = 8'hFF; cpha = 1'b1;
      end else if (lat == 10) begin
        start = 1'b0; cs_sel = 3'd1; tx = 8'h12; cpha = 1'b0;
      end
      if (lat == 12) chk("busy-start cs", 64'(cs_n), 64'(4'b1101));
    end
    chk("busy-start latency", 64'(lat), 64'(68));
    chk("busy-start rx", 64'(rx), 64'(8'h34));
    chk("busy-start slave rx", 64'(slv_rx), 64'(8'h12));
    chk("b2b gap cs", 64'(cs_n), 64'(4'hF));
    $display("[TB] busy-start sel=1 tx=12 rx=%h lat=%0d", rx, lat);
    slv_word = 8'h77; cs_sel = 3'd3; tx = 8'h5E; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b cs after 1 cycle", 64'(cs_n), 64'(4'b0111));
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b latency", 64'(lat), 64'(68));
    chk("b2b rx", 64'(rx), 64'(8'h77));
    chk("b2b slave rx", 64'(slv_rx), 64'(8'h5E));
    $display("[TB] back-to-back sel=3 tx=5e rx=%h lat=%0d", rx, lat);
    @(posedge clk); #1;

    // Invalid slave index.
    cs_sel = 3'd4; tx = 8'hAA; start = 1'b1;
    chk("err before", 64'(err), 64'(1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    chk("err pulse", 64'(err), 64'(1'b1));
    chk("err cs", 64'(cs_n), 64'(4'hF));
    chk("err busy", 64'(busy), 64'(1'b0));
    @(posedge clk); #1;
    chk("err clears", 64'(err), 64'(1'b0));
    chk("err busy after", 64'(busy), 64'(1'b0));
    $display("[TB] invalid sel=4 err seen, cs=%b busy=%0d", cs_n, busy);

    // Reset in the middle of a CPOL=1 transfer.
    cpol = 1'b1; cpha = 1'b0; lsb = 1'b0; cs_sel = 3'd0; tx = 8'h3F;
    slv_cpol = 1'b1; slv_cpha = 1'b0; slv_lsb = 1'b0; slv_word = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst cs", 64'(cs_n), 64'(4'hF));
    chk("midrst sclk", 64'(sclk), 64'(1'b0));
    chk("midrst busy", 64'(busy), 64'(1'b0));
    chk("midrst rx", 64'(rx), 64'(0));
    chk("midrst mosi", 64'(mosi), 64'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("midrst no done", 64'(seen), 64'(0));
    chk("midrst rx stays", 64'(rx), 64'(0));
    $display("[TB] reset mid-transfer cs=%b sclk=%0d rx=%h", cs_n, sclk, rx);

    // DATA_W=16, CLK_DIV=1 loopback.
    for (int k = 0; k < 2; k++) begin
      cpol16 = (k == 1); cpha16 = (k == 1); lsb16 = (k == 1);
      sel16 = 1'(k); tx16 = exp16[k]; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      chk($sformatf("w16_%0d cs", k), 64'(cs16), 64'((k == 0) ? 2'b10 : 2'b01));
      lat = 0;
      while (!done16 && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("w16_%0d latency", k), 64'(lat), 64'(33));
      chk($sformatf("w16_%0d rx", k), 64'(rx16), 64'(exp16[k]));
      chk($sformatf("w16_%0d cs end", k), 64'(cs16), 64'(2'b11));
      chk($sformatf("w16_%0d busy end", k), 64'(busy16), 64'(1'b0));
      $display("[TB] w16_%0d mode=%0d tx=%h rx=%h lat=%0d", k, k * 3, tx16, rx16, lat);
      @(posedge clk); #1;
    end
    chk("w16 no err", 64'(err16), 64'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
